// File: rtl/word_packer_pkg.sv
// Shared constants for the word packer / unpacker pair: code points,
// secondary-code points, field lengths and the length lookup.
package wordpack_pkg;

   localparam int LINE_W     = 128;               // output line width
   localparam int CODE_W     = 2;                 // code / code_bak width
   localparam int DICT_WORDS = 16;                // dictionary entries
   localparam int IDX_W      = $clog2(DICT_WORDS);
   localparam int LEN_W      = 6;                 // field-length width
   localparam int PAYLOAD_W  = 32;                // literal input width
   localparam int FIELD_W    = 34;                // longest field

   // Primary codes
   localparam logic [CODE_W-1:0] CODE_ZZZZ = 2'b00;
   localparam logic [CODE_W-1:0] CODE_XXXX = 2'b01;
   localparam logic [CODE_W-1:0] CODE_MMMM = 2'b10;
   localparam logic [CODE_W-1:0] CODE_EXT  = 2'b11;

   // Secondary codes, meaningful only under CODE_EXT
   localparam logic [CODE_W-1:0] BAK_MMXX = 2'b00;
   localparam logic [CODE_W-1:0] BAK_ZZZX = 2'b01;
   localparam logic [CODE_W-1:0] BAK_MMMX = 2'b10;
   localparam logic [CODE_W-1:0] BAK_MXXX = 2'b11;

   // Field lengths in bits, code bits included
   localparam logic [LEN_W-1:0] LEN_ZZZZ = 6'd2;
   localparam logic [LEN_W-1:0] LEN_XXXX = 6'd34;
   localparam logic [LEN_W-1:0] LEN_MMMM = 6'd6;
   localparam logic [LEN_W-1:0] LEN_MMXX = 6'd24;
   localparam logic [LEN_W-1:0] LEN_ZZZX = 6'd12;
   localparam logic [LEN_W-1:0] LEN_MMMX = 6'd16;
   localparam logic [LEN_W-1:0] LEN_MXXX = 6'd32;

   // Field length for a code pair; the unpacker's length generator uses
   // the same table so both ends always agree on field boundaries.
   function automatic logic [LEN_W-1:0] field_len(input logic [CODE_W-1:0] code,
                                                  input logic [CODE_W-1:0] code_bak);
      logic [LEN_W-1:0] len;
      case (code)
         CODE_ZZZZ: len = LEN_ZZZZ;
         CODE_XXXX: len = LEN_XXXX;
         CODE_MMMM: len = LEN_MMMM;
         CODE_EXT: begin
            case (code_bak)
               BAK_MMXX: len = LEN_MMXX;
               BAK_ZZZX: len = LEN_ZZZX;
               BAK_MMMX: len = LEN_MMMX;
               BAK_MXXX: len = LEN_MXXX;
               default:  len = LEN_ZZZZ;
            endcase
         end
         default: len = LEN_ZZZZ;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/word_packer_formatter.sv
// Combinational field builder: turns one encoded word into a right-aligned
// variable-length field (code in the low bits) plus its length.
module word_formatter
   import wordpack_pkg::*;
(
   input  logic [CODE_W-1:0]    code,
   input  logic [CODE_W-1:0]    code_bak,
   input  logic [IDX_W-1:0]     idx,
   input  logic [PAYLOAD_W-1:0] payload,
   output logic [FIELD_W-1:0]   field,
   output logic [LEN_W-1:0]     len
);

   // Assemble the field bits for the selected code; unused bits stay zero
   always_comb begin
      field = {FIELD_W{1'b0}};
      len   = field_len(code, code_bak);
      case (code)
         CODE_ZZZZ: field = {32'h0, code};
         CODE_XXXX: field = {payload, code};
         CODE_MMMM: field = {28'h0, idx, code};
         CODE_EXT: begin
            case (code_bak)
               BAK_MMXX: field = {10'h0, payload[15:0], idx, code_bak, code};
               BAK_ZZZX: field = {22'h0, payload[7:0], code_bak, code};
               BAK_MMMX: field = {18'h0, payload[7:0], idx, code_bak, code};
               BAK_MXXX: field = {2'h0, payload[23:0], idx, code_bak, code};
               default:  field = {FIELD_W{1'b0}};
            endcase
         end
         default: field = {FIELD_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/word_packer.sv
// Bit packer: appends formatted fields LSB-first into a continuous stream
// and hands out WIDTH-bit lines; a flush emits the trailing partial line.
module word_packer
   import wordpack_pkg::*;
#(
   parameter int WIDTH  = LINE_W,
   parameter int CODE   = CODE_W,
   parameter int WORD   = DICT_WORDS,
   parameter int LENGTH = LEN_W
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [CODE-1:0]            i_code,
   input  logic [CODE-1:0]            i_code_bak,
   input  logic [$clog2(WORD)-1:0]    i_idx,
   input  logic [31:0]                i_payload,
   input  logic                       i_flush,
   output logic                       o_line_valid,
   input  logic                       i_line_ready,
   output logic [WIDTH-1:0]           o_line,
   output logic [$clog2(WIDTH):0]     o_line_bits,
   output logic                       o_flush_done
);

   localparam int FILL_W = $clog2(2*WIDTH);
   localparam int BITS_W = $clog2(WIDTH) + 1;
   localparam logic [FILL_W-1:0] FILL_LINE = FILL_W'(WIDTH);

   logic [FIELD_W-1:0]   field_s;
   logic [LENGTH-1:0]    len_s;
   logic [2*WIDTH-1:0]   field_shift_s;
   logic [WIDTH-1:0]     tail_mask_s;
   logic                 ready_s;
   logic                 accept_s;
   logic                 slot_free_s;
   logic                 move_s;
   logic                 flush_emit_s;
   logic                 flush_empty_s;
   logic                 flush_taken_s;

   logic [2*WIDTH-1:0]   acc_r;
   logic [FILL_W-1:0]    fill_r;
   logic                 flush_pend_r;
   logic                 flush_line_r;   // slot currently holds the flush line
   logic                 line_valid_r;
   logic [WIDTH-1:0]     line_r;
   logic [BITS_W-1:0]    line_bits_r;
   logic                 flush_done_r;

   word_formatter u_formatter (
      .code     (i_code),
      .code_bak (i_code_bak),
      .idx      (i_idx),
      .payload  (i_payload),
      .field    (field_s),
      .len      (len_s)
   );

   // Handshake and move/flush decisions; accept, move and flush-emit are
   // mutually exclusive because they need disjoint fill/flush states.
   always_comb begin
      ready_s       = !i_reset && (fill_r < FILL_LINE) && !flush_pend_r;
      accept_s      = i_valid && ready_s;
      slot_free_s   = !line_valid_r || i_line_ready;
      move_s        = (fill_r >= FILL_LINE) && slot_free_s;
      flush_emit_s  = flush_pend_r && !flush_line_r && (fill_r != {FILL_W{1'b0}})
                      && (fill_r < FILL_LINE) && slot_free_s;
      flush_empty_s = flush_pend_r && !flush_line_r && (fill_r == {FILL_W{1'b0}});
      flush_taken_s = line_valid_r && i_line_ready && flush_line_r;
      field_shift_s = {{(2*WIDTH-FIELD_W){1'b0}}, field_s} << fill_r;
      tail_mask_s   = ~({WIDTH{1'b1}} << fill_r);
   end

   // Accumulator and fill counter: append on accept, drop a line on move
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_r  <= {(2*WIDTH){1'b0}};
         fill_r <= {FILL_W{1'b0}};
      end else if (accept_s) begin
         acc_r  <= acc_r | field_shift_s;
         fill_r <= fill_r + {{(FILL_W-LENGTH){1'b0}}, len_s};
      end else if (move_s) begin
         acc_r  <= acc_r >> WIDTH;
         fill_r <= fill_r - FILL_LINE;
      end else if (flush_emit_s) begin
         acc_r  <= {(2*WIDTH){1'b0}};
         fill_r <= {FILL_W{1'b0}};
      end else begin
         acc_r  <= acc_r;
         fill_r <= fill_r;
      end
   end

   // Output slot: load a full or flush line when free, hold while stalled
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         line_valid_r <= 1'b0;
         line_r       <= {WIDTH{1'b0}};
         line_bits_r  <= {BITS_W{1'b0}};
         flush_line_r <= 1'b0;
      end else if (move_s) begin
         line_valid_r <= 1'b1;
         line_r       <= acc_r[WIDTH-1:0];
         line_bits_r  <= BITS_W'(WIDTH);
         flush_line_r <= 1'b0;
      end else if (flush_emit_s) begin
         line_valid_r <= 1'b1;
         line_r       <= acc_r[WIDTH-1:0] & tail_mask_s;
         line_bits_r  <= BITS_W'(fill_r);
         flush_line_r <= 1'b1;
      end else if (line_valid_r && i_line_ready) begin
         line_valid_r <= 1'b0;
         flush_line_r <= 1'b0;
      end else begin
         line_valid_r <= line_valid_r;
         flush_line_r <= flush_line_r;
      end
   end

   // Flush control: latch the request, finish when the tail line is taken
   // or immediately when nothing is left to emit
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         flush_pend_r <= 1'b0;
         flush_done_r <= 1'b0;
      end else if (flush_taken_s || flush_empty_s) begin
         flush_pend_r <= 1'b0;
         flush_done_r <= 1'b1;
      end else if (i_flush && !flush_pend_r) begin
         flush_pend_r <= 1'b1;
         flush_done_r <= 1'b0;
      end else begin
         flush_pend_r <= flush_pend_r;
         flush_done_r <= 1'b0;
      end
   end

   assign o_ready      = ready_s;
   assign o_line_valid = line_valid_r;
   assign o_line       = line_r;
   assign o_line_bits  = line_bits_r;
   assign o_flush_done = flush_done_r;

endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer.
module tb_word_packer;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_valid;
   logic          o_ready;
   logic [1:0]    i_code;
   logic [1:0]    i_code_bak;
   logic [3:0]    i_idx;
   logic [31:0]   i_payload;
   logic          i_flush;
   logic          o_line_valid;
   logic          i_line_ready;
   logic [127:0]  o_line;
   logic [7:0]    o_line_bits;
   logic          o_flush_done;

   int n_cmp = 0;
   int n_mis = 0;
   int done_cnt = 0;
   logic [127:0] line_q[$];
   logic [7:0]   bits_q[$];

   word_packer dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_code       (i_code),
      .i_code_bak   (i_code_bak),
      .i_idx        (i_idx),
      .i_payload    (i_payload),
      .i_flush      (i_flush),
      .o_line_valid (o_line_valid),
      .i_line_ready (i_line_ready),
      .o_line       (o_line),
      .o_line_bits  (o_line_bits),
      .o_flush_done (o_flush_done)
   );

   always #5 i_clk = ~i_clk;

   // Record every consumed line and every flush-done pulse
   always @(posedge i_clk) begin
      if (o_line_valid && i_line_ready) begin
         line_q.push_back(o_line);
         bits_q.push_back(o_line_bits);
      end
      if (o_flush_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_word(input logic [1:0] code, input logic [1:0] bak,
                            input logic [3:0] idx, input logic [31:0] payload,
                            input logic flush);
      int t;
      i_code     = code;
      i_code_bak = bak;
      i_idx      = idx;
      i_payload  = payload;
      i_valid    = 1'b1;
      i_flush    = flush;
      t = 0;
      while (!o_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) check("send_timeout", 128'(o_ready), 128'd1);
      tick();
      i_valid = 1'b0;
      i_flush = 1'b0;
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
   endtask

   task automatic wait_lines(input int n, input string tag);
      int t;
      t = 0;
      while (line_q.size() < n && t < 200) begin
         tick();
         t++;
      end
      check(tag, 128'(line_q.size()), 128'(n));
   endtask

   task automatic clear_log();
      line_q.delete();
      bits_q.delete();
      done_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  a, b, c, d;
      logic [127:0] exp1;
      logic [31:0]  p5[8];
      logic [271:0] stream5;

      i_reset = 1'b1; i_valid = 1'b0; i_code = 2'b00; i_code_bak = 2'b00;
      i_idx = 4'd0; i_payload = 32'd0; i_flush = 1'b0; i_line_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_ready",  128'(o_ready), 128'd0);
      check("rst_valid",  128'(o_line_valid), 128'd0);
      check("rst_line",   o_line, 128'd0);
      check("rst_bits",   128'(o_line_bits), 128'd0);
      check("rst_done",   128'(o_flush_done), 128'd0);
      i_reset = 1'b0;
      tick();
      check("rst_ready_after", 128'(o_ready), 128'd1);

      // 1: 64 zero words fill exactly one line; later flush has nothing left
      clear_log();
      for (int i = 0; i < 64; i++) send_word(2'b00, 2'b00, 4'd0, 32'd0, 1'b0);
      wait_lines(1, "t1_lines");
      check("t1_line", line_q[0], 128'd0);
      check("t1_bits", 128'(bits_q[0]), 128'd128);
      do_flush();
      repeat (4) tick();
      check("t1_done", 128'(done_cnt), 128'd1);
      check("t1_noline", 128'(line_q.size()), 128'd1);

      // 2: mmmm idx=5, flush -> 0x16 / 6 bits
      clear_log();
      send_word(2'b10, 2'b00, 4'd5, 32'd0, 1'b0);
      do_flush();
      wait_lines(1, "t2_lines");
      repeat (3) tick();
      check("t2_line", line_q[0], 128'h16);
      check("t2_bits", 128'(bits_q[0]), 128'd6);
      check("t2_done", 128'(done_cnt), 128'd1);

      // 3: mmxx with flush in the same cycle -> word packed first
      clear_log();
      send_word(2'b11, 2'b00, 4'd3, 32'h0000BEEF, 1'b1);
      wait_lines(1, "t3_lines");
      repeat (3) tick();
      check("t3_line", line_q[0], 128'hBEEF33);
      check("t3_bits", 128'(bits_q[0]), 128'd24);
      check("t3_done", 128'(done_cnt), 128'd1);

      // 4: four literals straddle a line; line valid one cycle after accept
      clear_log();
      a = 32'h89ABCDEF; b = 32'h13579BDF; c = 32'h2468ACE0; d = 32'hF0E1D2C3;
      send_word(2'b01, 2'b00, 4'd0, a, 1'b0);
      send_word(2'b01, 2'b00, 4'd0, b, 1'b0);
      send_word(2'b01, 2'b00, 4'd0, c, 1'b0);
      send_word(2'b01, 2'b00, 4'd0, d, 1'b0);
      check("t4_lat_pre", 128'(o_line_valid), 128'd0);
      tick();
      check("t4_lat_post", 128'(o_line_valid), 128'd1);
      exp1 = {d[23:0], 2'b01, c, 2'b01, b, 2'b01, a, 2'b01};
      wait_lines(1, "t4_lines1");
      check("t4_line1", line_q[0], exp1);
      check("t4_bits1", 128'(bits_q[0]), 128'd128);
      do_flush();
      wait_lines(2, "t4_lines2");
      repeat (3) tick();
      check("t4_line2", line_q[1], 128'hF0);
      check("t4_bits2", 128'(bits_q[1]), 128'd8);
      check("t4_done", 128'(done_cnt), 128'd1);

      // 5: consumer stalled across two lines
      clear_log();
      i_line_ready = 1'b0;
      stream5 = '0;
      for (int i = 0; i < 8; i++) begin
         p5[i] = 32'h1357_9BDF ^ (32'h0101_0101 * (i + 1));
         stream5 = stream5 | (272'({p5[i], 2'b01}) << (34 * i));
      end
      for (int i = 0; i < 8; i++) send_word(2'b01, 2'b00, 4'd0, p5[i], 1'b0);
      repeat (3) tick();
      check("t5_ready_low", 128'(o_ready), 128'd0);
      check("t5_valid", 128'(o_line_valid), 128'd1);
      check("t5_line_hold1", o_line, stream5[127:0]);
      repeat (4) tick();
      check("t5_line_hold2", o_line, stream5[127:0]);
      check("t5_bits_hold", 128'(o_line_bits), 128'd128);
      check("t5_none_taken", 128'(line_q.size()), 128'd0);
      i_line_ready = 1'b1;
      wait_lines(2, "t5_lines2");
      check("t5_line1", line_q[0], stream5[127:0]);
      check("t5_line2", line_q[1], stream5[255:128]);
      do_flush();
      wait_lines(3, "t5_lines3");
      repeat (3) tick();
      check("t5_line3", line_q[2], 128'(stream5[271:256]));
      check("t5_bits3", 128'(bits_q[2]), 128'd16);
      check("t5_done", 128'(done_cnt), 128'd1);

      // 6: reset with 40 bits pending discards them
      clear_log();
      send_word(2'b01, 2'b00, 4'd0, 32'hDEADBEEF, 1'b0);
      send_word(2'b10, 2'b00, 4'd1, 32'd0, 1'b0);
      i_reset = 1'b1;
      tick();
      check("t6_ready_rst", 128'(o_ready), 128'd0);
      i_reset = 1'b0;
      tick();
      check("t6_ready", 128'(o_ready), 128'd1);
      check("t6_valid", 128'(o_line_valid), 128'd0);
      do_flush();
      repeat (5) tick();
      check("t6_noline", 128'(line_q.size()), 128'd0);
      check("t6_done", 128'(done_cnt), 128'd1);

      // 7: extended codes zzzx, mmmx, mxxx packed back to back
      clear_log();
      send_word(2'b11, 2'b01, 4'd0, 32'h000000A5, 1'b0);
      send_word(2'b11, 2'b10, 4'd9, 32'h0000003C, 1'b0);
      send_word(2'b11, 2'b11, 4'd2, 32'h00123456, 1'b1);
      wait_lines(1, "t7_lines");
      repeat (3) tick();
      check("t7_line", line_q[0], 128'h1234562F3C9BA57);
      check("t7_bits", 128'(bits_q[0]), 128'd60);
      check("t7_done", 128'(done_cnt), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
